// File: rtl/eq_pkg.sv
// Shared equalizer definitions: AXI-Lite widths, register map and the
// configuration-master write FSM state type.
package eq_pkg;

  localparam int C_S00_AXIL_ADDR_WIDTH = 7;
  localparam int C_S00_AXIL_DATA_WIDTH = 32;
  localparam int DATA_WIDTH            = 16;
  localparam int BOUNDARIES_WIDTH      = 10;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ADDR_DATA = 2'd1,
    RESP      = 2'd2
  } axil_wr_state_t;

  // Equalizer register map (byte addresses on the s00_axil port)
  localparam logic [C_S00_AXIL_ADDR_WIDTH-1:0] REG_GAIN_LOW       = 7'h00;
  localparam logic [C_S00_AXIL_ADDR_WIDTH-1:0] REG_GAIN_MID       = 7'h04;
  localparam logic [C_S00_AXIL_ADDR_WIDTH-1:0] REG_GAIN_HIGH      = 7'h08;
  localparam logic [C_S00_AXIL_ADDR_WIDTH-1:0] REG_BOUND_LOW_MID  = 7'h0C;
  localparam logic [C_S00_AXIL_ADDR_WIDTH-1:0] REG_BOUND_MID_HIGH = 7'h10;

endpackage

// File: rtl/eq_cmd_fifo.sv
// Small synchronous command FIFO with a registered occupancy count.
// Read data is presented from the head entry whenever the FIFO is non-empty.
module eq_cmd_fifo #(
  parameter int WIDTH = 39,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the pointers/count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/eq_axil_cfg_master.sv
// AXI-Lite write initiator that drains queued (addr, data) requests into the
// equalizer's configuration slave, one single-beat write at a time.
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   IDLE      | waiting for a queued request; pops and launches AW+W
//   ADDR_DATA | AW and W valids outstanding, each retired independently
//   RESP      | bready high, waiting for the slave's write response
module eq_axil_cfg_master
  import eq_pkg::*;
#(
  parameter int C_M00_AXIL_ADDR_WIDTH = C_S00_AXIL_ADDR_WIDTH,
  parameter int C_M00_AXIL_DATA_WIDTH = C_S00_AXIL_DATA_WIDTH,
  parameter int FIFO_DEPTH            = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [C_M00_AXIL_ADDR_WIDTH-1:0] req_addr,
  input  logic [C_M00_AXIL_DATA_WIDTH-1:0] req_data,
  output logic [C_M00_AXIL_ADDR_WIDTH-1:0] m00_axil_awaddr,
  output logic                             m00_axil_awvalid,
  input  logic                             m00_axil_awready,
  output logic [C_M00_AXIL_DATA_WIDTH-1:0] m00_axil_wdata,
  output logic                             m00_axil_wvalid,
  input  logic                             m00_axil_wready,
  input  logic                             m00_axil_bvalid,
  output logic                             m00_axil_bready,
  output logic                             busy,
  output logic                             wr_done,
  output logic [15:0]                      wr_count
);

  localparam int AW = C_M00_AXIL_ADDR_WIDTH;
  localparam int DW = C_M00_AXIL_DATA_WIDTH;

  axil_wr_state_t state, state_d;

  logic          fifo_full, fifo_empty, fifo_pop;
  logic [AW+DW-1:0] fifo_head;

  logic [AW-1:0] awaddr_q;
  logic [DW-1:0] wdata_q;
  logic          awvalid_q, wvalid_q, bready_q, wr_done_q;
  logic [15:0]   wr_count_q;

  logic          awvalid_d, wvalid_d, bready_d, wr_done_d, load_cmd, cnt_inc;
  logic          aw_done, w_done;

  eq_cmd_fifo #(
    .WIDTH (AW + DW),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (req_valid && req_ready),
    .push_data ({req_addr, req_data}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // A channel counts as done once its valid has dropped or is handshaking now.
  assign aw_done = !awvalid_q || m00_axil_awready;
  assign w_done  = !wvalid_q  || m00_axil_wready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:      if (!fifo_empty)                     state_d = ADDR_DATA;
      ADDR_DATA: if (aw_done && w_done)               state_d = RESP;
      RESP:      if (m00_axil_bvalid && bready_q)     state_d = IDLE;
      default:                                        state_d = IDLE;
    endcase
  end

  always_comb begin
    fifo_pop  = 1'b0;
    load_cmd  = 1'b0;
    cnt_inc   = 1'b0;
    wr_done_d = 1'b0;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          load_cmd  = 1'b1;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
        end
      end
      ADDR_DATA: begin
        if (awvalid_q && m00_axil_awready) awvalid_d = 1'b0;
        if (wvalid_q && m00_axil_wready)   wvalid_d  = 1'b0;
        if (aw_done && w_done)             bready_d  = 1'b1;
      end
      RESP: begin
        if (m00_axil_bvalid && bready_q) begin
          bready_d  = 1'b0;
          wr_done_d = 1'b1;
          cnt_inc   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      awaddr_q   <= '0;
      wdata_q    <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      wr_done_q  <= 1'b0;
      wr_count_q <= '0;
    end else begin
      if (load_cmd) begin
        awaddr_q <= fifo_head[AW+DW-1:DW];
        wdata_q  <= fifo_head[DW-1:0];
      end
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      wr_done_q <= wr_done_d;
      if (cnt_inc) wr_count_q <= wr_count_q + 16'd1;
    end
  end

  // Held low during reset so nothing is accepted into a FIFO being cleared.
  assign req_ready        = !fifo_full && !rst;
  assign busy             = !fifo_empty || (state != IDLE);
  assign m00_axil_awaddr  = awaddr_q;
  assign m00_axil_awvalid = awvalid_q;
  assign m00_axil_wdata   = wdata_q;
  assign m00_axil_wvalid  = wvalid_q;
  assign m00_axil_bready  = bready_q;
  assign wr_done          = wr_done_q;
  assign wr_count         = wr_count_q;

endmodule

// File: tb/tb_eq_axil_cfg_master.sv
// Self-checking bench for eq_axil_cfg_master: a behavioural AXI-Lite slave
// with programmable ready/response delays and an address/data scoreboard.
module tb_eq_axil_cfg_master;

  localparam int AW = 7;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic [AW-1:0] awaddr;
  logic          awvalid;
  logic          awready;
  logic [DW-1:0] wdata;
  logic          wvalid;
  logic          wready;
  logic          bvalid;
  logic          bready;
  logic          busy;
  logic          wr_done;
  logic [15:0]   wr_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int exp_cnt = 0;

  logic [AW-1:0] aw_q [$];
  logic [DW-1:0] w_q  [$];

  int aw_dly  = 0;
  int w_dly   = 0;
  int b_delay = 0;
  bit aw_hold = 0;

  int aw_age, w_age, bwait;
  bit aw_seen, w_seen, b_fire;

  eq_axil_cfg_master #(
    .C_M00_AXIL_ADDR_WIDTH (AW),
    .C_M00_AXIL_DATA_WIDTH (DW),
    .FIFO_DEPTH            (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_addr         (req_addr),
    .req_data         (req_data),
    .m00_axil_awaddr  (awaddr),
    .m00_axil_awvalid (awvalid),
    .m00_axil_awready (awready),
    .m00_axil_wdata   (wdata),
    .m00_axil_wvalid  (wvalid),
    .m00_axil_wready  (wready),
    .m00_axil_bvalid  (bvalid),
    .m00_axil_bready  (bready),
    .busy             (busy),
    .wr_done          (wr_done),
    .wr_count         (wr_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: drives readies/bvalid on the falling edge and pops the
  // scoreboard for every AW/W handshake that the next rising edge completes.
  initial begin
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    aw_seen = 0; w_seen = 0; b_fire = 0; aw_age = 0; w_age = 0; bwait = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        aw_seen = 0; w_seen = 0; b_fire = 0; aw_age = 0; w_age = 0; bwait = 0;
        continue;
      end
      if (b_fire) begin bvalid = 1'b0; b_fire = 0; end
      if (aw_seen && w_seen && !bvalid) begin
        if (bwait == 0) begin bvalid = 1'b1; aw_seen = 0; w_seen = 0; end
        else bwait--;
      end
      awready = !aw_hold && (aw_age >= aw_dly);
      wready  = (w_age >= w_dly);
      if (awvalid && awready) begin
        total++;
        if (aw_q.size() == 0) begin
          bad++; $display("FAIL aw_scoreboard: awaddr=%h issued with nothing pending", awaddr);
        end else begin
          ea = aw_q.pop_front();
          if (awaddr !== ea) begin bad++; $display("FAIL aw_scoreboard: awaddr=%h expected %h", awaddr, ea); end
        end
        aw_seen = 1; bwait = b_delay; aw_age = 0;
      end else if (awvalid) aw_age++;
      if (wvalid && wready) begin
        total++;
        if (w_q.size() == 0) begin
          bad++; $display("FAIL w_scoreboard: wdata=%h issued with nothing pending", wdata);
        end else begin
          ed = w_q.pop_front();
          if (wdata !== ed) begin bad++; $display("FAIL w_scoreboard: wdata=%h expected %h", wdata, ed); end
        end
        w_seen = 1; bwait = b_delay; w_age = 0;
      end else if (wvalid) w_age++;
      if (bvalid && bready) b_fire = 1;
    end
  end

  // Call on a falling edge; returns on the falling edge after acceptance.
  task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    req_valid = 1'b1; req_addr = a; req_data = d;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    if (!req_ready) begin
      total++; bad++;
      $display("FAIL send_timeout: req_ready=%b required 1 for addr %h", req_ready, a);
    end else begin
      aw_q.push_back(a); w_q.push_back(d);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!wr_done && n < budget) begin @(negedge clk); n++; end
    total++;
    if (!wr_done) begin bad++; $display("FAIL %s_done_timeout: wr_done=%b required 1", tag, wr_done); end
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0;
    @(negedge clk); @(negedge clk);
    total++;
    if ({awvalid, wvalid, bready, busy, wr_done, req_ready} !== 6'b0) begin
      bad++; $display("FAIL reset_ctl: aw/w/b/busy/done/rdy=%b required 000000",
                      {awvalid, wvalid, bready, busy, wr_done, req_ready});
    end
    total++;
    if ({awaddr, wdata, wr_count} !== '0) begin
      bad++; $display("FAIL reset_data: awaddr=%h wdata=%h wr_count=%h required 0", awaddr, wdata, wr_count);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_release: req_ready=%b busy=%b required 1/0", req_ready, busy);
    end
  endtask

  task automatic test_single;
    send(7'h04, 32'h00AB_CDEF);                       // returns in N+1
    total++;
    if (awvalid !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL single_n1: awvalid=%b busy=%b required 0/1", awvalid, busy);
    end
    @(negedge clk);                                   // N+2
    total++;
    if ({awvalid, wvalid} !== 2'b11 || awaddr !== 7'h04 || wdata !== 32'h00AB_CDEF) begin
      bad++; $display("FAIL single_n2: awvalid=%b wvalid=%b awaddr=%h wdata=%h required 1 1 04 00abcdef",
                      awvalid, wvalid, awaddr, wdata);
    end
    @(negedge clk);                                   // N+3
    total++;
    if (bready !== 1'b1 || awvalid !== 1'b0 || wvalid !== 1'b0) begin
      bad++; $display("FAIL single_n3: bready=%b awvalid=%b wvalid=%b required 1 0 0", bready, awvalid, wvalid);
    end
    @(negedge clk);                                   // N+4
    exp_cnt++;
    total++;
    if (wr_done !== 1'b1 || wr_count !== 16'(exp_cnt) || busy !== 1'b0) begin
      bad++; $display("FAIL single_n4: wr_done=%b wr_count=%0d busy=%b required 1 %0d 0",
                      wr_done, wr_count, busy, exp_cnt);
    end
    @(negedge clk);
    total++;
    if (wr_done !== 1'b0) begin bad++; $display("FAIL single_pulse: wr_done=%b required 0", wr_done); end
  endtask

  task automatic test_back_to_back;
    int t0;
    int rel [3];
    int nseen = 0;
    t0 = cyc;
    fork
      begin
        send(7'h00, 32'h0000_0011);
        send(7'h08, 32'h0000_0022);
        send(7'h0C, 32'h0000_0033);
      end
      begin
        for (int i = 0; i < 30 && nseen < 3; i++) begin
          @(negedge clk);
          if (awvalid) begin rel[nseen] = cyc - t0; nseen++; end
        end
      end
    join
    total++;
    if (nseen != 3 || rel[0] != 2 || rel[1] != 5 || rel[2] != 8) begin
      bad++; $display("FAIL b2b_spacing: seen=%0d awvalid at +%0d +%0d +%0d required 3 at +2 +5 +8",
                      nseen, rel[0], rel[1], rel[2]);
    end
    repeat (4) @(negedge clk);
    exp_cnt += 3;
    total++;
    if (wr_count !== 16'(exp_cnt) || busy !== 1'b0) begin
      bad++; $display("FAIL b2b_count: wr_count=%0d busy=%b required %0d 0", wr_count, busy, exp_cnt);
    end
  endtask

  task automatic test_skewed;
    int aw_hi = 0, w_hi = 0, first_b = -1, last_w = -1;
    bit data_ok = 1, b_early = 0;
    aw_dly = 1; w_dly = 5;
    send(7'h08, 32'h1234_5678);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (awvalid) aw_hi++;
      if (wvalid) begin
        w_hi++; last_w = i;
        if (wdata !== 32'h1234_5678 || awaddr !== 7'h08) data_ok = 0;
      end
      if (bready && first_b < 0) first_b = i;
      if (bready && (wvalid || awvalid)) b_early = 1;
    end
    aw_dly = 0; w_dly = 0;
    total++;
    if (aw_hi != 2 || w_hi != 6) begin
      bad++; $display("FAIL skew_valids: awvalid cycles=%0d wvalid cycles=%0d required 2 6", aw_hi, w_hi);
    end
    total++;
    if (!data_ok) begin bad++; $display("FAIL skew_hold: data_stable=%0d required 1", data_ok); end
    total++;
    if (b_early || first_b != last_w + 1) begin
      bad++; $display("FAIL skew_bready: early=%0d first bready=%0d required 0 and %0d", b_early, first_b, last_w + 1);
    end
    exp_cnt++;
    total++;
    if (wr_count !== 16'(exp_cnt)) begin
      bad++; $display("FAIL skew_count: wr_count=%0d required %0d", wr_count, exp_cnt);
    end
  endtask

  task automatic test_fifo_full;
    aw_hold = 1;
    for (int k = 0; k < 5; k++) send(7'(4 * k), 32'hA000_0000 + 32'(k));
    total++;
    if (req_ready !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL full_ready: req_ready=%b busy=%b required 0 1", req_ready, busy);
    end
    repeat (3) @(negedge clk);
    total++;
    if (req_ready !== 1'b0 || awvalid !== 1'b1 || awaddr !== 7'h00) begin
      bad++; $display("FAIL full_hold: req_ready=%b awvalid=%b awaddr=%h required 0 1 00", req_ready, awvalid, awaddr);
    end
    aw_hold = 0;
    for (int k = 0; k < 5; k++) begin
      wait_done("full", 20);
      @(negedge clk);
    end
    exp_cnt += 5;
    total++;
    if (wr_count !== 16'(exp_cnt) || aw_q.size() != 0 || busy !== 1'b0) begin
      bad++; $display("FAIL full_drain: wr_count=%0d pending=%0d busy=%b required %0d 0 0",
                      wr_count, aw_q.size(), busy, exp_cnt);
    end
  endtask

  task automatic test_slow_resp;
    int n = 0;
    b_delay = 10;
    send(7'h10, 32'h0000_0AAA);
    send(7'h00, 32'h0000_0BBB);
    while (!bready && n < 20) begin @(negedge clk); n++; end
    for (int i = 0; i < 10; i++) begin
      total++;
      if (bready !== 1'b1 || awvalid !== 1'b0 || busy !== 1'b1) begin
        bad++; $display("FAIL slow_wait%0d: bready=%b awvalid=%b busy=%b required 1 0 1", i, bready, awvalid, busy);
      end
      @(negedge clk);
    end
    wait_done("slow_a", 10);
    b_delay = 0;
    @(negedge clk);
    wait_done("slow_b", 20);
    exp_cnt += 2;
    total++;
    if (wr_count !== 16'(exp_cnt)) begin
      bad++; $display("FAIL slow_count: wr_count=%0d required %0d", wr_count, exp_cnt);
    end
    @(negedge clk);
  endtask

  task automatic reset_and_check(input string tag);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({awvalid, wvalid, bready, busy, wr_done, req_ready} !== 6'b0 ||
        {awaddr, wdata, wr_count} !== '0) begin
      bad++; $display("FAIL %s: ctl=%b awaddr=%h wdata=%h wr_count=%h required all 0", tag,
                      {awvalid, wvalid, bready, busy, wr_done, req_ready}, awaddr, wdata, wr_count);
    end
    aw_q.delete(); w_q.delete();
    aw_hold = 0; b_delay = 0; exp_cnt = 0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int n = 0;
    aw_hold = 1;
    send(7'h0C, 32'hDEAD_BEEF);
    while (!awvalid && n < 10) begin @(negedge clk); n++; end
    reset_and_check("reset_addr_data");
    b_delay = 5;
    send(7'h10, 32'h0000_0055);
    n = 0;
    while (!bready && n < 10) begin @(negedge clk); n++; end
    reset_and_check("reset_resp");
    test_single();
  endtask

  task automatic test_wrap;
    @(negedge clk);
    force dut.wr_count_q = 16'hFFFE;
    @(negedge clk);
    release dut.wr_count_q;
    send(7'h04, 32'h0000_0001);
    wait_done("wrap_a", 10);
    total++;
    if (wr_count !== 16'hFFFF) begin bad++; $display("FAIL wrap_ffff: wr_count=%h required ffff", wr_count); end
    @(negedge clk);
    send(7'h08, 32'h0000_0002);
    wait_done("wrap_b", 10);
    total++;
    if (wr_count !== 16'h0000) begin bad++; $display("FAIL wrap_zero: wr_count=%h required 0000", wr_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_skewed();
    test_fifo_full();
    test_slow_resp();
    test_reset_mid();
    test_wrap();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

endmodule

// File: doc/eq_axil_cfg_master.md
# eq_axil_cfg_master

AXI-Lite write initiator that programs the equalizer's configuration registers: amplification gains and band boundaries. It accepts (address, data) write requests on a simple valid/ready port and buffers them in a small command FIFO. Each request is issued as a single AXI-Lite write burst on the AW, W and B channels, which connect directly to the equalizer's `s00_axil_*` slave port. The block sits between the testbench/processor-side configuration sequencer and the equalizer core.

## Interface
- `C_M00_AXIL_ADDR_WIDTH`, 7, AXI-Lite address width (matches the slave).
- `C_M00_AXIL_DATA_WIDTH`, 32, AXI-Lite data width.
- `FIFO_DEPTH`, 4, command FIFO entries; must be a power of 2, ≥2.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  write request valid.
- `req_ready`  out  1  request accepted when `req_valid & req_ready`.
- `req_addr`  in  ADDR_WIDTH  register byte address.
- `req_data`  in  DATA_WIDTH  register write data.
- `m00_axil_awaddr`  out  ADDR_WIDTH  write address.
- `m00_axil_awvalid`  out  1  address valid.
- `m00_axil_awready`  in  1  slave address ready.
- `m00_axil_wdata`  out  DATA_WIDTH  write data.
- `m00_axil_wvalid`  out  1  data valid.
- `m00_axil_wready`  in  1  slave data ready.
- `m00_axil_bvalid`  in  1  write response valid (no BRESP; the slave does not provide one).
- `m00_axil_bready`  out  1  response ready.
- `busy`  out  1  FIFO non-empty or FSM not IDLE.
- `wr_done`  out  1  one-cycle pulse per completed write.
- `wr_count`  out  16  completed writes since reset; wraps 0xFFFF→0.

## Operation
- `req_ready` = FIFO not full; purely combinational from the registered FIFO count.
- FIFO push on request handshake. The FSM pops only in IDLE.
- A simultaneous push and pop on a full FIFO is not possible: `req_ready` is low when full.
- FSM states and transitions:
  - IDLE: when the FIFO is non-empty, pop, register addr/data into `awaddr`/`wdata`, set `awvalid`=`wvalid`=1, go to ADDR_DATA.
  - ADDR_DATA: `awvalid` clears on the cycle after `awvalid & awready`; `wvalid` likewise, each independently. When both handshakes are done (either one may occur this cycle), set `bready`=1 and go to RESP.
  - RESP: on `bvalid & bready`, clear `bready`, pulse `wr_done` next cycle, increment `wr_count`, go to IDLE.
- `awaddr`/`wdata` are held stable from `valid` assertion until both handshakes complete.
- Valids are never deasserted before their handshake.
- `bvalid` seen outside RESP is ignored; the slave must not produce it.
- Reset, including mid-transaction: all outputs go to 0 immediately, the FIFO empties, and the FSM returns to IDLE. Reset values:
  - `req_ready`=0 while `rst` is high, 1 after.
  - `awaddr`=0, `wdata`=0, all valids/`bready`=0, `busy`=0, `wr_done`=0, `wr_count`=0.

## Timing
- Request accepted in cycle N (empty FIFO, IDLE):
  - FIFO entry visible in N+1.
  - Pop in N+1; `awvalid`/`wvalid` high from N+2.
- Both readies high at N+2: `bready` high from N+3. `bvalid` at N+3: `wr_done` pulses at N+4, and FSM is IDLE at N+4.
- Back-to-back minimum spacing: 3 cycles per write (`awvalid` at N+2, N+5, N+8, …).
- `awready` and `wready` may arrive in any order, with arbitrary delay, or in the same cycle.

## Structure
- Shared package `eq_pkg`:
  - Width parameters: `C_S00_AXIL_ADDR_WIDTH`, `C_S00_AXIL_DATA_WIDTH`, `DATA_WIDTH`, `BOUNDARIES_WIDTH`.
  - FSM state enum `axil_wr_state_t` {IDLE, ADDR_DATA, RESP}.
  - Equalizer register address constants.
- Sub-module `eq_cmd_fifo`: synchronous FIFO, parameterised width/depth, registered count, outputs full/empty. Same clock and reset.

## Test plan
- Single write: req addr=0x04, data=0x00ABCDEF, slave readies tied high → AW/W valid at N+2 with those values, `wr_done` at N+4, `wr_count`=1.
- Skewed readies: `awready` at cycle +1, `wready` at cycle +5 → `awvalid` drops after its handshake, `wdata` held until the W handshake, `bready` asserted only after both.
- FIFO full: 5 requests with `awready`=0 → `req_ready` low after the 4th is buffered. Release → 4 writes in order, then the 5th, `wr_count`=5.
- Slow response: `bvalid` delayed 10 cycles → `bready` held high throughout, no new AW issued, `busy`=1.
- Reset while in ADDR_DATA and in RESP → all outputs 0 asynchronously, FIFO empty, next request behaves as the single-write case.
- Counter wrap: preload via 65536 writes (or force) → `wr_count` goes 0xFFFF→0x0000.
